memctl: RTL and testbench

//   Memory bus sequencer downstream of the register file's 16-bit ADDR_out bus.

---
 rtl/memctl.sv | 110 +++++++++++
 tb/tb_memctl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/memctl.sv
// memctl: byte-wide async-SRAM sequencer (IDLE -> SETUP -> ACCESS -> DONE) with wait states.
// Define MEMCTL_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles and flag ERR.
module memctl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  WRITE,
    input  logic                  POSTINC,
    input  logic [ADDR_WIDTH-1:0] ADDR_in,
    input  logic [DATA_WIDTH-1:0] DATA_in,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  ADDR_INC,
    output logic                  ERR,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_DATA_out,
    output logic                  MEM_DATA_OE,
    output logic                  MEM_OE_bar,
    output logic                  MEM_WE_bar,
    input  logic [DATA_WIDTH-1:0] MEM_DATA_in,
    input  logic                  MEM_READY
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] wcnt;
    logic       wr, postinc, acc_exit, abort;

    if (WAIT_STATES > 15 || TIMEOUT < 1) begin : g_param_check
        $error("memctl: WAIT_STATES must be 0..15 and TIMEOUT >= 1");
    end

    assign acc_exit = state == ST_ACCESS && wcnt >= 4'(WAIT_STATES) && MEM_READY;

    always_comb begin
        state_nxt = state;
        state_nxt = state == ST_IDLE   ? (START ? ST_SETUP : ST_IDLE) :
                    state == ST_SETUP  ? ST_ACCESS :
                    state == ST_ACCESS ? (acc_exit || abort ? ST_DONE : ST_ACCESS) :
                    ST_IDLE;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            wcnt         <= '0;
            wr           <= 1'b0;
            postinc      <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            ADDR_INC     <= 1'b0;
            RDATA        <= '0;
            MEM_ADDR     <= '0;
            MEM_DATA_out <= '0;
            MEM_DATA_OE  <= 1'b0;
            MEM_OE_bar   <= 1'b1;
            MEM_WE_bar   <= 1'b1;
        end else begin
            state <= state_nxt;
            wcnt  <= state == ST_ACCESS ? wcnt + {3'b000, wcnt != 4'hF} : '0;
            if (state == ST_IDLE && START) begin
                wr           <= WRITE;
                postinc      <= POSTINC;
                MEM_ADDR     <= ADDR_in;
                MEM_DATA_out <= DATA_in;
            end
            if (acc_exit && !wr)
                RDATA <= MEM_DATA_in;
            BUSY        <= state_nxt != ST_IDLE;
            DONE        <= state_nxt == ST_DONE;
            ADDR_INC    <= state_nxt == ST_DONE && postinc && !abort;
            MEM_DATA_OE <= state_nxt == ST_ACCESS && wr;
            MEM_OE_bar  <= !(state_nxt == ST_ACCESS && !wr);
            MEM_WE_bar  <= !(state_nxt == ST_ACCESS && wr);
        end
    end

`ifdef MEMCTL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;

    // A normal exit on the final allowed cycle takes priority over the abort.
    assign abort = state == ST_ACCESS && !acc_exit && tcnt == TW'(TIMEOUT - 1);
    assign ERR   = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            tcnt <= state == ST_ACCESS ? tcnt + 1'b1 : '0;
            if (state == ST_IDLE && START)
                err_q <= 1'b0;
            else if (abort)
                err_q <= 1'b1;
        end
    end
`else
    assign abort = 1'b0;
    assign ERR   = 1'b0;
`endif
endmodule

// File: tb/tb_memctl.sv
// tb_memctl: directed checks of memctl strobe timing, wait states, START filtering and reset.
module tb_memctl;
    localparam int WS = 1;

    logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, WRITE = 1'b0, POSTINC = 1'b0, MEM_READY = 1'b0;
    logic [15:0] ADDR_in = '0, MEM_ADDR;
    logic [7:0]  DATA_in = '0, MEM_DATA_in = '0, RDATA, MEM_DATA_out;
    logic        BUSY, DONE, ADDR_INC, ERR, MEM_DATA_OE, MEM_OE_bar, MEM_WE_bar;

    int   n_chk = 0, n_pass = 0;
    int   r_done, r_oe, r_we, r_bad_addr, r_bad_dout, r_bad_doe, stray;
    logic r_ainc, r_err;

    memctl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(WS), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST), .START(START), .WRITE(WRITE), .POSTINC(POSTINC),
        .ADDR_in(ADDR_in), .DATA_in(DATA_in), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA),
        .ADDR_INC(ADDR_INC), .ERR(ERR), .MEM_ADDR(MEM_ADDR), .MEM_DATA_out(MEM_DATA_out),
        .MEM_DATA_OE(MEM_DATA_OE), .MEM_OE_bar(MEM_OE_bar), .MEM_WE_bar(MEM_WE_bar),
        .MEM_DATA_in(MEM_DATA_in), .MEM_READY(MEM_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle following DONE.
    // r_done is the cycle number in which DONE is sampled, START-sampling edge = cycle 0.
    task automatic run_req(input logic w, input logic [15:0] a, input logic [7:0] d,
                           input logic pinc, input int extra, input bit mid);
        int n = 0;
        r_done = 0; r_oe = 0; r_we = 0; r_bad_addr = 0; r_bad_dout = 0; r_bad_doe = 0;
        r_ainc = 1'b0; r_err = 1'b0;
        WRITE = w; ADDR_in = a; DATA_in = d; POSTINC = pinc; START = 1'b1;
        @(posedge CLK);
        for (int e = 0; e < 200; e++) begin
            @(negedge CLK);
            START   = mid && (e == 0 || e == 1);
            ADDR_in = ~a;
            DATA_in = ~d;
            if (MEM_ADDR !== a) r_bad_addr++;
            if (w && MEM_DATA_out !== d) r_bad_dout++;
            if (MEM_DATA_OE !== !MEM_WE_bar) r_bad_doe++;
            if (!MEM_OE_bar) r_oe++;
            if (!MEM_WE_bar) r_we++;
            if (!MEM_OE_bar || !MEM_WE_bar) n++;
            MEM_READY = n >= WS + 1 + extra;
            if (DONE) begin
                r_done = e + 1; r_ainc = ADDR_INC; r_err = ERR;
                break;
            end
            @(posedge CLK);
        end
        START = 1'b0; MEM_READY = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_ainc", ADDR_INC, 0);
        check("rst_err", ERR, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_addr", MEM_ADDR, 0);
        check("rst_dout", MEM_DATA_out, 0);
        check("rst_doe", MEM_DATA_OE, 0);
        check("rst_oe", MEM_OE_bar, 1);
        check("rst_we", MEM_WE_bar, 1);
        START = 1'b1; ADDR_in = 16'hFFFF;
        @(posedge CLK); @(negedge CLK);
        check("rst_start_busy", BUSY, 0);
        check("rst_start_addr", MEM_ADDR, 0);
        RST = 1'b0; START = 1'b0;
        @(negedge CLK);

        MEM_DATA_in = 8'hA5;
        run_req(1'b0, 16'h1234, 8'h00, 1'b1, 0, 1'b0);
        check("t1_done_cyc", r_done, 3 + WS);
        check("t1_oe_cycles", r_oe, 2);
        check("t1_we_cycles", r_we, 0);
        check("t1_ainc", r_ainc, 1);
        check("t1_err", r_err, 0);
        check("t1_rdata", RDATA, 8'hA5);
        check("t1_addr_stable", r_bad_addr, 0);
        check("t1_idle_busy", BUSY, 0);

        MEM_DATA_in = 8'h11;
        run_req(1'b1, 16'h8000, 8'h3C, 1'b0, 0, 1'b0);
        check("t2_done_cyc", r_done, 3 + WS);
        check("t2_we_cycles", r_we, 2);
        check("t2_oe_cycles", r_oe, 0);
        check("t2_doe_with_we", r_bad_doe, 0);
        check("t2_dout", r_bad_dout, 0);
        check("t2_ainc", r_ainc, 0);
        check("t2_rdata_held", RDATA, 8'hA5);

        MEM_DATA_in = 8'h5A;
        run_req(1'b0, 16'h0F0F, 8'h00, 1'b0, 3, 1'b0);
        check("t3_done_cyc", r_done, 7);
        check("t3_oe_cycles", r_oe, 5);
        check("t3_addr_stable", r_bad_addr, 0);
        check("t3_rdata", RDATA, 8'h5A);

        MEM_DATA_in = 8'h77;
        run_req(1'b0, 16'h4321, 8'h00, 1'b1, 0, 1'b1);
        check("t4_done_cyc", r_done, 3 + WS);
        check("t4_addr_stable", r_bad_addr, 0);
        check("t4_rdata", RDATA, 8'h77);
        check("t4_after_busy", BUSY, 0);
        run_req(1'b1, 16'h0001, 8'h99, 1'b1, 0, 1'b0);
        check("t4_next_done_cyc", r_done, 3 + WS);
        check("t4_next_ainc", r_ainc, 1);
        stray = 0;
        repeat (4) begin
            @(negedge CLK);
            if (DONE || BUSY) stray++;
        end
        check("t4_no_extra_done", stray, 0);

        WRITE = 1'b0; ADDR_in = 16'h2222; START = 1'b1;
        @(posedge CLK); @(negedge CLK);
        START = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check("t5_in_access", MEM_OE_bar, 0);
        RST = 1'b1; MEM_READY = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check("t5_oe", MEM_OE_bar, 1);
        check("t5_we", MEM_WE_bar, 1);
        check("t5_busy", BUSY, 0);
        check("t5_rdata", RDATA, 0);
        check("t5_done", DONE, 0);
        check("t5_addr", MEM_ADDR, 0);
        RST = 1'b0; MEM_READY = 1'b0;
        stray = 0;
        repeat (5) begin
            @(negedge CLK);
            if (DONE || ADDR_INC || BUSY) stray++;
        end
        check("t5_no_done", stray, 0);

`ifdef MEMCTL_TIMEOUT_EN
        MEM_DATA_in = 8'hEE;
        run_req(1'b0, 16'h0ABC, 8'h00, 1'b1, 1000, 1'b0);
        check("t6_done_cyc", r_done, 66);
        check("t6_oe_cycles", r_oe, 64);
        check("t6_err", r_err, 1);
        check("t6_ainc", r_ainc, 0);
        check("t6_rdata_kept", RDATA, 0);
        check("t6_err_sticky", ERR, 1);
        MEM_DATA_in = 8'h42;
        run_req(1'b0, 16'h0ABD, 8'h00, 1'b0, 0, 1'b0);
        check("t6_err_cleared", r_err, 0);
        check("t6_next_rdata", RDATA, 8'h42);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
